// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order instruction-memory requests from
// the program counter, buffers returned words with their PCs and hands them
// to decode. A redirect from execute flushes everything in flight.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] pc_in,
  output logic [31:0] overwrite_pc,
  output logic        overwrite_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_W = DEPTH[CNT_W:0];

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] outstanding, occupancy;
  logic [CNT_W-1:0] discard_cnt, discard_nxt;
  logic [PTR_W-1:0] tag_wr_ptr, tag_rd_ptr;
  logic [PTR_W-1:0] buf_wr_ptr, buf_rd_ptr;

  logic [31:0] tag_mem  [DEPTH];
  logic [31:0] buf_data [DEPTH];
  logic [31:0] buf_pc   [DEPTH];

  logic credit_ok;
  logic issue;
  logic rsp_accept;
  logic rsp_on_redirect;
  logic pop;

  // Credit uses registered counts only, so a same-cycle pop does not free a slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_W;

  assign imem_req_addr  = {pc_in[31:2], 2'b00};
  assign imem_req_valid = nrst && credit_ok && !redirect_valid && (state == RUN);
  assign issue          = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_accept      = (state == RUN) && !redirect_valid && imem_rsp_valid &&
                           (outstanding != '0);
  assign rsp_on_redirect = imem_rsp_valid && (outstanding != '0);

  assign instr_valid = nrst && (occupancy != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = buf_data[buf_rd_ptr];
  assign instr_pc    = buf_pc[buf_rd_ptr];

  // PC control: redirect wins, otherwise hold the PC whenever nothing issues.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    overwrite_valid = 1'b0;
    overwrite_pc    = pc_in;
    if (!nrst) begin
      overwrite_valid = 1'b0;
    end else if (redirect_valid) begin
      overwrite_valid = 1'b1;
      overwrite_pc    = redirect_pc;
    end else if (!issue) begin
      overwrite_valid = 1'b1;
    end
  end

  // Next-state and discard-count logic for the RUN/FLUSH machine.
  always_comb begin
    state_nxt   = state;
    discard_nxt = discard_cnt;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          // A response arriving in the redirect cycle is already dropped here.
          discard_nxt = outstanding - CNT_W'(rsp_on_redirect);
          if (discard_nxt != '0) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // A further redirect keeps the count; stale responses still drain it.
        if (imem_rsp_valid && (discard_cnt != '0)) begin
          discard_nxt = discard_cnt - CNT_W'(1);
          if (discard_nxt == '0) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register with synchronous reset; reset abandons any pending discards.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nrst) begin
      state       <= RUN;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
    end
  end

  // Counts and queue pointers; a redirect empties both queues.
  always_ff @(posedge clk) begin
    if (!nrst || redirect_valid) begin
      outstanding <= '0;
      occupancy   <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      buf_wr_ptr  <= '0;
      buf_rd_ptr  <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp_accept);
      occupancy   <= occupancy + CNT_W'(rsp_accept) - CNT_W'(pop);
      if (issue)      tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
      if (rsp_accept) tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      if (rsp_accept) buf_wr_ptr <= buf_wr_ptr + PTR_W'(1);
      if (pop)        buf_rd_ptr <= buf_rd_ptr + PTR_W'(1);
    end
  end

  // Tag queue and instruction buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; the pointers and counts alone decide which entries are live.
    if (issue) tag_mem[tag_wr_ptr] <= pc_in;
    if (rsp_accept) begin
      buf_data[buf_wr_ptr] <= imem_rsp_data;
      buf_pc[buf_wr_ptr]   <= tag_mem[tag_rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (DEPTH=2): a PC model and an in-order
// memory model surround the DUT; expected deliveries go into a scoreboard
// queue that a separate monitor drains on every decode handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] pc_in;
  logic [31:0] overwrite_pc;
  logic        overwrite_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(2)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .pc_in           (pc_in),
    .overwrite_pc    (overwrite_pc),
    .overwrite_valid (overwrite_valid),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          issue_cnt = 0;
  mem_req_t    pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic        cap_rst, cap_ov;
  logic [31:0] cap_ovpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program counter and instruction memory models.
  initial begin
    pc_in          = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cap_rst  = nrst;
      cap_ov   = overwrite_valid;
      cap_ovpc = overwrite_pc;
      if (nrst && imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        issue_cnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!cap_rst)    pc_in = 32'h0;
      else if (cap_ov) pc_in = cap_ovpc;
      else             pc_in = pc_in + 32'd4;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // Scoreboard monitor: compares every delivered instruction.
  initial forever begin
    @(negedge clk);
    if (nrst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h, nothing expected", instr_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("instr_pc", instr_pc, mon_exp);
        check("instr_data", instr_data, mem_word(mon_exp));
      end
    end
  end

  // Address alignment and redirect routing, checked continuously.
  initial forever begin
    @(negedge clk);
    if (nrst && imem_req_valid) check("req_addr", imem_req_addr, {pc_in[31:2], 2'b00});
    if (nrst && redirect_valid) begin
      check("redirect_ov_valid", overwrite_valid, 32'd1);
      check("redirect_ov_pc", overwrite_pc, redirect_pc);
      check("redirect_req_valid", imem_req_valid, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nrst           = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req_valid", imem_req_valid, 32'd0);
      check("rst_instr_valid", instr_valid, 32'd0);
      check("rst_ov_valid", overwrite_valid, 32'd0);
      tick();
    end
    nrst = 1'b1;
  endtask

  task automatic finish_test(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check({name, "_all_delivered"}, exp_q.size(), 32'd0);
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    n = 0;
    while (pend.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int n;
    nrst           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;

    // Streaming from reset, with a 3-cycle memory stall at pc 0x10.
    lat            = 1;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    do_reset();
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    check("first_ov_valid", overwrite_valid, 32'd0);
    check("first_instr_valid", instr_valid, 32'd0);
    n = 0;
    while (pc_in != 32'h10 && n < 50) begin
      tick();
      n++;
    end
    check("stall_reached_pc10", pc_in, 32'h10);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mstall_ov_valid", overwrite_valid, 32'd1);
      check("mstall_ov_pc", overwrite_pc, 32'h10);
      tick();
    end
    imem_req_ready = 1'b1;
    finish_test("stream");

    // Decode stall: two requests fill the window, then the PC holds at 8.
    lat            = 1;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    do_reset();
    issue_cnt = 0;
    repeat (5) tick();
    @(negedge clk);
    check("dstall_issue_cnt", issue_cnt, 32'd2);
    check("dstall_req_valid", imem_req_valid, 32'd0);
    check("dstall_ov_valid", overwrite_valid, 32'd1);
    check("dstall_ov_pc", overwrite_pc, 32'h8);
    check("dstall_instr_valid", instr_valid, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    tick();
    instr_ready = 1'b1;
    finish_test("dstall");

    // Redirect with two outstanding (latency 3): both stale words dropped.
    lat            = 3;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("redir2_ov_pc", overwrite_pc, 32'h100);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_req_valid_a", imem_req_valid, 32'd0);
    check("flush_ov_valid", overwrite_valid, 32'd1);
    check("flush_ov_pc", overwrite_pc, 32'h100);
    tick();
    @(negedge clk);
    check("flush_req_valid_b", imem_req_valid, 32'd0);
    tick();
    @(negedge clk);
    check("postflush_req_valid", imem_req_valid, 32'd1);
    check("postflush_req_addr", imem_req_addr, 32'h100);
    finish_test("redir2");

    // Redirect in the same cycle as the only response: no FLUSH.
    lat            = 1;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("samecyc_rsp_present", imem_rsp_valid, 32'd1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("samecyc_req_valid", imem_req_valid, 32'd1);
    check("samecyc_req_addr", imem_req_addr, 32'h100);
    check("samecyc_instr_valid", instr_valid, 32'd0);
    finish_test("samecyc");

    // Reset for one cycle in the middle of a FLUSH.
    lat            = 3;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    nrst           = 1'b0;
    @(negedge clk);
    check("rflush_rst_instr_valid", instr_valid, 32'd0);
    check("rflush_rst_req_valid", imem_req_valid, 32'd0);
    check("rflush_rst_ov_valid", overwrite_valid, 32'd0);
    tick();
    nrst = 1'b1;
    @(negedge clk);
    check("rflush_run_req_valid", imem_req_valid, 32'd1);
    check("rflush_run_req_addr", imem_req_addr, 32'h0);
    check("rflush_run_instr_valid", instr_valid, 32'd0);
    tick();
    @(negedge clk);
    check("rflush_stale_ignored", instr_valid, 32'd0);
    check("rflush_req_addr_hold", imem_req_addr, 32'h0);
    tick();
    lat = 1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    imem_req_ready = 1'b1;
    finish_test("rflush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
